// File: rtl/snd_pwmfeeder.sv
// snd_pwmfeeder
// Write-side feeder for the PWM sample buffer. Takes 16-bit signed PCM samples
// on a valid/ready handshake and requantizes each into OSR duty codes in
// 0..LEVELS using first-order error-feedback noise shaping. The codes are
// written into the PWM buffer FIFO.
//
// Ports
//   ACLK           system clock
//   ARST           synchronous active-high reset
//   COMMAND[1:0]   01 play, 00/10 pause, 11 flush (registered once before use)
//   S_DATA[15:0]   signed PCM sample
//   S_VALID        sample valid
//   S_READY        sample accepted when S_VALID & S_READY at an edge
//   pwmBUF_WREADY  buffer can take a write this cycle
//   pwmBUF_WR      registered write strobe, one cycle per code
//   pwm_dout[3:0]  registered duty code; holds when no write occurs
//   UNDRCNT[15:0]  saturating count of starved write slots
//
// state   | meaning
// --------+---------------------------------------------------------
// ST_IDLE | waiting for a sample; counts underruns while playing
// ST_EMIT | writing OSR codes for samp_q, stalls while WREADY is low

module snd_pwmfeeder #(
   parameter int OSR    = 8,
   parameter int LEVELS = 12
) (
   input  logic        ACLK,
   input  logic        ARST,
   input  logic [1:0]  COMMAND,
   input  logic [15:0] S_DATA,
   input  logic        S_VALID,
   output logic        S_READY,
   input  logic        pwmBUF_WREADY,
   output logic        pwmBUF_WR,
   output logic [3:0]  pwm_dout,
   output logic [15:0] UNDRCNT
);

   typedef enum logic {ST_IDLE, ST_EMIT} state_t;

   state_t      state_q, state_d;
   logic [1:0]  com_q, com_d;
   logic [15:0] samp_q, samp_d;
   logic [15:0] err_q, err_d;
   logic [3:0]  rep_q, rep_d;
   logic        wr_q, wr_d;
   logic [3:0]  dout_q, dout_d;
   logic [15:0] undr_q, undr_d;

   logic        play;
   logic        flush;
   logic [19:0] acc;

   always_ff @(posedge ACLK) begin
      if (ARST) begin
         state_q <= ST_IDLE;
         com_q   <= 2'b00;
         samp_q  <= 16'd0;
         err_q   <= 16'd0;
         rep_q   <= 4'd0;
         wr_q    <= 1'b0;
         dout_q  <= 4'd0;
         undr_q  <= 16'd0;
      end else begin
         state_q <= state_d;
         com_q   <= com_d;
         samp_q  <= samp_d;
         err_q   <= err_d;
         rep_q   <= rep_d;
         wr_q    <= wr_d;
         dout_q  <= dout_d;
         undr_q  <= undr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      com_d   = COMMAND;
      samp_d  = samp_q;
      err_d   = err_q;
      rep_d   = rep_q;
      wr_d    = 1'b0;
      dout_d  = dout_q;
      undr_d  = undr_q;

      play  = (com_q == 2'b01);
      flush = (com_q == 2'b11);
      // Worst case 65535*LEVELS + 65535 still fits in 20 bits for LEVELS <= 15,
      // and the top nibble can never exceed LEVELS, so no clamp is needed.
      acc   = 20'(samp_q) * 20'(LEVELS) + {4'd0, err_q};

      if (flush) begin
         // Buffer is being reset alongside us: abort and write nothing.
         state_d = ST_IDLE;
         err_d   = 16'd0;
         rep_d   = 4'd0;
         undr_d  = 16'd0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (play && S_VALID) begin
                  samp_d  = {~S_DATA[15], S_DATA[14:0]};
                  rep_d   = 4'd0;
                  state_d = ST_EMIT;
               end else if (play && pwmBUF_WREADY && (undr_q != 16'hFFFF)) begin
                  undr_d = undr_q + 16'd1;
               end
            end
            ST_EMIT: begin
               if (pwmBUF_WREADY) begin
                  dout_d = acc[19:16];
                  err_d  = acc[15:0];
                  wr_d   = 1'b1;
                  rep_d  = rep_q + 4'd1;
                  if (rep_q == 4'(OSR - 1)) begin
                     state_d = ST_IDLE;
                  end
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   assign S_READY   = (state_q == ST_IDLE) && (com_q == 2'b01);
   assign pwmBUF_WR = wr_q;
   assign pwm_dout  = dout_q;
   assign UNDRCNT   = undr_q;

endmodule

// File: tb/tb_snd_pwmfeeder.sv
module tb_snd_pwmfeeder;

   localparam int OSR    = 8;
   localparam int LEVELS = 12;

   logic        ACLK = 1'b0;
   logic        ARST;
   logic [1:0]  COMMAND;
   logic [15:0] S_DATA;
   logic        S_VALID;
   logic        S_READY;
   logic        pwmBUF_WREADY;
   logic        pwmBUF_WR;
   logic [3:0]  pwm_dout;
   logic [15:0] UNDRCNT;

   snd_pwmfeeder #(.OSR(OSR), .LEVELS(LEVELS)) dut (
      .ACLK(ACLK), .ARST(ARST), .COMMAND(COMMAND),
      .S_DATA(S_DATA), .S_VALID(S_VALID), .S_READY(S_READY),
      .pwmBUF_WREADY(pwmBUF_WREADY), .pwmBUF_WR(pwmBUF_WR),
      .pwm_dout(pwm_dout), .UNDRCNT(UNDRCNT)
   );

   always #5 ACLK = ~ACLK;

   int n_cmp = 0;
   int n_err = 0;

   // behavioural model: registered command, queue of codes still to be written
   int m_com;
   int m_q[$];
   int m_err;
   int m_undr;
   int m_wr;
   int m_dout;
   int wlog[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // A sample is requantized all at once: OSR codes plus the carried error.
   task automatic model_edge();
      int u, acc;
      if (ARST) begin
         m_com = 0; m_q.delete(); m_err = 0; m_undr = 0; m_wr = 0; m_dout = 0;
         return;
      end
      m_wr = 0;
      if (m_com == 3) begin
         m_q.delete(); m_err = 0; m_undr = 0;
      end else if (m_q.size() != 0) begin
         if (pwmBUF_WREADY) begin
            m_wr = 1;
            m_dout = m_q.pop_front();
         end
      end else if (m_com == 1) begin
         if (S_VALID) begin
            u = int'(S_DATA) ^ 32'h8000;
            for (int i = 0; i < OSR; i++) begin
               acc = u * LEVELS + m_err;
               m_q.push_back(acc / 65536);
               m_err = acc % 65536;
            end
         end else if (pwmBUF_WREADY && m_undr < 65535) begin
            m_undr++;
         end
      end
      m_com = int'(COMMAND);
   endtask

   task automatic step();
      @(posedge ACLK);
      model_edge();
      @(negedge ACLK);
      chk("s_ready", 32'(S_READY), 32'(m_com == 1 && m_q.size() == 0));
      chk("wr", 32'(pwmBUF_WR), m_wr);
      chk("dout", 32'(pwm_dout), m_dout);
      chk("undrcnt", 32'(UNDRCNT), m_undr);
      if (pwmBUF_WR === 1'b1) wlog.push_back(int'(pwm_dout));
   endtask

   task automatic feed(input logic [15:0] d);
      int i = 0;
      S_DATA  = d;
      S_VALID = 1'b1;
      while (S_READY !== 1'b1 && i < 50) begin
         step();
         i++;
      end
      chk("feed_ready_timeout", 32'(i < 50), 32'd1);
      step();
      S_VALID = 1'b0;
   endtask

   task automatic wait_writes(input int n, input bit toggle);
      int start = wlog.size();
      int i = 0;
      while (wlog.size() < start + n && i < 200) begin
         if (toggle) pwmBUF_WREADY = (i % 4 == 0) || (i % 4 == 3);
         step();
         i++;
      end
      pwmBUF_WREADY = 1'b1;
      chk("writes_seen", 32'(wlog.size() - start), 32'(n));
   endtask

   task automatic chk_code(input string name, input int idx, input int exp);
      chk(name, (idx < wlog.size()) ? 32'(wlog[idx]) : 32'hFFFF_FFFF, 32'(exp));
   endtask

   initial begin
      int base, saved;
      ARST = 1'b1; COMMAND = 2'b00; S_DATA = 16'h0; S_VALID = 1'b0; pwmBUF_WREADY = 1'b1;
      m_com = 0; m_err = 0; m_undr = 0; m_wr = 0; m_dout = 0;
      repeat (3) step();
      ARST = 1'b0;
      step();
      chk("rst_s_ready", 32'(S_READY), 32'd0);
      chk("rst_wr", 32'(pwmBUF_WR), 32'd0);
      chk("rst_dout", 32'(pwm_dout), 32'd0);
      chk("rst_undrcnt", 32'(UNDRCNT), 32'd0);

      // midscale: S_READY one cycle after play, first write one cycle after EMIT entry
      COMMAND = 2'b01; S_DATA = 16'h0000; S_VALID = 1'b1;
      step();
      chk("ready_after_cmd", 32'(S_READY), 32'd1);
      base = wlog.size();
      step();
      S_VALID = 1'b0;
      chk("no_wr_on_accept", 32'(pwmBUF_WR), 32'd0);
      step();
      chk("first_wr_latency", 32'(pwmBUF_WR), 32'd1);
      wait_writes(OSR - 1, 1'b0);
      for (int i = 0; i < OSR; i++) chk_code("mid_code", base + i, 6);

      base = wlog.size();
      feed(16'h1000);
      wait_writes(OSR, 1'b0);
      chk_code("c1000_0", base + 0, 6); chk_code("c1000_1", base + 1, 7);
      chk_code("c1000_2", base + 2, 7); chk_code("c1000_3", base + 3, 7);
      chk_code("c1000_4", base + 4, 6); chk_code("c1000_5", base + 5, 7);
      chk_code("c1000_6", base + 6, 7); chk_code("c1000_7", base + 7, 7);

      base = wlog.size();
      feed(16'h8000);
      wait_writes(OSR, 1'b0);
      for (int i = 0; i < OSR; i++) chk_code("min_code", base + i, 0);
      base = wlog.size();
      feed(16'h7FFF);
      wait_writes(OSR, 1'b0);
      chk_code("max_code0", base, 11);
      for (int i = 1; i < OSR; i++) chk_code("max_code", base + i, 12);

      // stalled emission keeps the count and sequence
      base = wlog.size();
      feed(16'h2345);
      wait_writes(OSR, 1'b1);
      repeat (20) step();
      chk("stall_total_writes", 32'(wlog.size() - base), 32'(OSR));

      // flush mid-sample, then a clean sample restarts from err = 0
      feed(16'h1000);
      wait_writes(3, 1'b0);
      COMMAND = 2'b11;
      repeat (4) step();
      saved = wlog.size();
      repeat (4) step();
      chk("flush_no_writes", 32'(wlog.size()), 32'(saved));
      chk("flush_undrcnt", 32'(UNDRCNT), 32'd0);
      chk("flush_s_ready", 32'(S_READY), 32'd0);
      COMMAND = 2'b01;
      base = wlog.size();
      feed(16'h4000);
      wait_writes(OSR, 1'b0);
      for (int i = 0; i < OSR; i++) chk_code("after_flush_code", base + i, 9);

      // reset mid-EMIT discards remaining codes
      feed(16'h1000);
      wait_writes(3, 1'b0);
      ARST = 1'b1;
      step();
      ARST = 1'b0;
      chk("rst_mid_wr", 32'(pwmBUF_WR), 32'd0);
      saved = wlog.size();
      repeat (12) step();
      chk("rst_mid_no_writes", 32'(wlog.size()), 32'(saved));

      // randomized traffic against the model
      for (int c = 0; c < 4000; c++) begin
         int r;
         if ($urandom_range(0, 19) == 0) begin
            r = $urandom_range(0, 99);
            COMMAND = (r < 85) ? 2'b01 : (r < 92) ? 2'b00 : (r < 96) ? 2'b10 : 2'b11;
         end
         S_VALID = 1'($urandom_range(0, 1));
         S_DATA = 16'($urandom());
         pwmBUF_WREADY = ($urandom_range(0, 3) != 0);
         ARST = ($urandom_range(0, 499) == 0);
         step();
      end
      ARST = 1'b0;

      // underrun saturation, then frozen under pause
      COMMAND = 2'b11; S_VALID = 1'b0; pwmBUF_WREADY = 1'b1;
      repeat (3) step();
      COMMAND = 2'b01;
      repeat (66000) step();
      chk("undr_saturated", 32'(UNDRCNT), 32'h0000_FFFF);
      COMMAND = 2'b00;
      repeat (20) step();
      chk("undr_frozen", 32'(UNDRCNT), 32'h0000_FFFF);
      chk("pause_s_ready", 32'(S_READY), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
